// File: rtl/bkm_pkg.sv
// Shared definitions for the BKM digit-selection slice:
// signed-digit output codes, CSD residual digit codes and FSM state encoding.
package bkm_pkg;

    // Selected complex-digit component codes
    localparam logic [1:0] D_ZERO = 2'b00;
    localparam logic [1:0] D_POS  = 2'b01;
    localparam logic [1:0] D_NEG  = 2'b11;

    // CSD residual digit codes {minus,plus}; 2'b11 is illegal
    localparam logic [1:0] CSD_P = 2'b01;
    localparam logic [1:0] CSD_N = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/csd_lead_estimate.sv
// Leading-digit estimator for one CSD residual: weights the top P digits
// into a signed estimate and thresholds it into a digit in {-1,0,+1}.
// Ports: res_i (2*W CSD residual), digit_o (D_* code), illegal_o (2'b11 seen).
module csd_lead_estimate
    import bkm_pkg::*;
#(
    parameter int W = 64,
    parameter int P = 4,
    parameter int T = 2
) (
    input  logic [2*W-1:0] res_i,
    output logic [1:0]     digit_o,
    output logic           illegal_o
);

    // |estimate| <= 2^P-1, so P+1 bits plus a guard bit
    localparam int EW = P + 2;
    localparam logic signed [EW-1:0] TH = EW'(T);

    logic signed [EW-1:0] est;
    logic signed [EW-1:0] wt;
    logic [1:0]           cd;

    // Only the leading P digits feed the estimate
    logic unused_low;
    assign unused_low = ^res_i[2*(W-P)-1:0];

    always_comb begin
        est       = '0;
        wt        = '0;
        cd        = '0;
        illegal_o = 1'b0;
        for (int k = 0; k < P; k++) begin
            cd = res_i[2*(W-1-k) +: 2];
            wt = EW'(1) << (P-1-k);
            case (cd)
                CSD_P:   est = est + wt;
                CSD_N:   est = est - wt;
                2'b11:   illegal_o = 1'b1;  // weighted as zero
                default: ;
            endcase
        end
        digit_o = D_ZERO;
        if (est >= TH) begin
            digit_o = D_POS;
        end else if (est <= -TH) begin
            digit_o = D_NEG;
        end
    end

endmodule

// File: rtl/bkm_digit_select.sv
// BKM digit-selection stage: sequences N_ITER iterations, samples the CSD
// residual each non-stalled RUN cycle and registers one complex digit.
// Ports: clk, arst, start, stall, res_x/res_y in; d_x/d_y, d_valid, iter,
// busy, done, err out.
module bkm_digit_select
    import bkm_pkg::*;
#(
    parameter int W      = 64,
    parameter int N_ITER = W,
    parameter int P      = 4,
    parameter int T      = 2
) (
    input  logic                      clk,
    input  logic                      arst,
    input  logic                      start,
    input  logic                      stall,
    input  logic [2*W-1:0]            res_x,
    input  logic [2*W-1:0]            res_y,
    output logic [1:0]                d_x,
    output logic [1:0]                d_y,
    output logic                      d_valid,
    output logic [$clog2(N_ITER)-1:0] iter,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int IW = $clog2(N_ITER);
    localparam logic [IW-1:0] LAST = IW'(N_ITER - 1);

    state_e        state_q, state_d;
    logic [1:0]    dx_q, dx_d, dy_q, dy_d;
    logic          dv_q, dv_d;
    logic [IW-1:0] iter_q, iter_d;
    logic          err_q, err_d;

    logic [1:0] est_x, est_y;
    logic       ill_x, ill_y;

    csd_lead_estimate #(.W(W), .P(P), .T(T)) u_est_x (
        .res_i     (res_x),
        .digit_o   (est_x),
        .illegal_o (ill_x)
    );

    csd_lead_estimate #(.W(W), .P(P), .T(T)) u_est_y (
        .res_i     (res_y),
        .digit_o   (est_y),
        .illegal_o (ill_y)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= ST_IDLE;
            dx_q    <= D_ZERO;
            dy_q    <= D_ZERO;
            dv_q    <= 1'b0;
            iter_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            dv_q    <= dv_d;
            iter_q  <= iter_d;
            err_q   <= err_d;
        end
    end

    // iter_q doubles as the iteration counter: the first sample of a run
    // (dv_q still low) issues index 0. The run ends once digit N_ITER-1
    // has been presented for a non-stalled cycle, so the index never wraps.
    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        dv_d    = dv_q;
        iter_d  = iter_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (!stall) begin
                    if (dv_q && (iter_q == LAST)) begin
                        state_d = ST_DONE;
                        dv_d    = 1'b0;
                    end else begin
                        dx_d   = est_x;
                        dy_d   = est_y;
                        dv_d   = 1'b1;
                        iter_d = dv_q ? iter_q + 1'b1 : '0;
                        if (ill_x || ill_y) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign d_x     = dx_q;
    assign d_y     = dy_q;
    assign d_valid = dv_q;
    assign iter    = iter_q;
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign err     = err_q;

endmodule
